ar_rxd_multi: RTL and testbench
===============================

AR_RXD_MULTI -- requirements
Module: ar_rxd_multi

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter FILT, default 4, consecutive clk cycles a line level must be stable before it is accepted.
REQ-003 Parameter TW, default 16, width of the internal timing counter.
REQ-004 clk  input  1  system clock; all flops on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 Inp1  input  1  ARINC-429 "one" line, asynchronous to clk.
REQ-007 Inp0  input  1  ARINC-429 "zero" line, asynchronous to clk.
REQ-008 speed  input  2  bit-rate select: 00=100 kbps, 01=50 kbps, 10=12.5 kbps, 11=reserved (treated as 12.5 kbps).
REQ-009 sr_adr  output  8  label of the last good-length word.
REQ-010 sr_dat  output  23  data bits 9..31 of the last good-length word.
REQ-011 par_ok  output  1  odd parity check result of the last word.
REQ-012 ce_wr  output  1  one-cycle strobe, word valid.
REQ-013 err_len  output  1  one-cycle strobe, word aborted with 1..31 bits.
REQ-014 err_gap  output  1  one-cycle strobe, inter-word gap too short.
REQ-015 err_code  output  1  one-cycle strobe, illegal line state (Inp1=Inp0=1).

Function
REQ-016 Inp1/Inp0 SHALL each pass a 2-flop synchronizer before any use.
REQ-017 Line state SHALL be decoded as ONE (10), ZERO (01), NULL (00) or ILLEGAL (11), and is accepted only after FILT consecutive identical synchronized samples.
REQ-018 Bit period P SHALL be CLK_HZ/rate clocks; gap threshold G = 2*P, recomputed from speed whenever the FSM is in SYNC.
REQ-019 A bit SHALL be taken on each accepted NULL->ONE or NULL->ZERO transition; its value is 1 for ONE.
REQ-020 FSM states SHALL be SYNC, IDLE, RX.
REQ-021 SYNC: a gap counter runs while NULL; on reaching G -> IDLE; on any accepted bit -> err_gap pulse, counter cleared, stay SYNC.
REQ-022 IDLE: first accepted bit -> RX with bit count 1.
REQ-023 RX: each accepted bit increments the count; the gap counter clears on each bit; NULL reaching G with count 1..31 -> err_len pulse, word discarded, go to IDLE.
REQ-024 Bit placement: bits 1..8 -> sr_adr[7]..sr_adr[0] (first received is MSB); bits 9..31 -> sr_dat[0]..sr_dat[22]; bit 32 -> parity.
REQ-025 On acceptance of bit 32: ce_wr SHALL pulse on the next clock, outputs update in the same cycle, FSM -> SYNC.
REQ-026 par_ok SHALL equal XOR of all 32 bits (1 = odd parity, correct).
REQ-027 sr_adr, sr_dat and par_ok SHALL hold between ce_wr pulses; aborted words SHALL NOT modify them.
REQ-028 Accepted ILLEGAL in any state SHALL cause an err_code pulse, discard the partial word, and go to SYNC.
REQ-029 At most one strobe (ce_wr, err_len, err_gap, err_code) SHALL be active per cycle; err_code has priority.
REQ-030 A speed change SHALL take effect only in SYNC; in IDLE/RX the latched rate is kept.
REQ-031 The gap counter SHALL saturate at 2^TW-1 (no wrap).

Reset
REQ-032 While rst=1: FSM=SYNC, counters 0, filters and synchronizers NULL, sr_adr=0, sr_dat=0, par_ok=0, all strobes 0.
REQ-033 rst asserted mid-word SHALL discard the word without any strobe; after release a full gap is required before the first word.

Verification (clk 50 MHz, speed=01, P=1000 clk, bit = 500 clk high + 500 clk NULL)
REQ-034 Idle NULL for 2000 clk, then word label 0x81, data 0x2AAAAA, parity bit set for odd -> one ce_wr, sr_adr=0x81, sr_dat=0x2AAAAA, par_ok=1.
REQ-035 Same word with the parity bit inverted -> ce_wr, par_ok=0, sr_adr/sr_dat as above.
REQ-036 Send 20 bits, then NULL for 2000 clk -> err_len pulse exactly once, no ce_wr, outputs unchanged.
REQ-037 Valid word, then a new bit after only 1000 clk NULL -> err_gap pulse, no word captured until a 2000-clk gap is seen.
REQ-038 Inp1=Inp0=1 for 10 clk during bit 5 -> err_code pulse, FSM to SYNC; a 3-clk 11 glitch -> no effect.
REQ-039 Switch speed to 00 in SYNC (P=500) and send a valid word -> ce_wr with correct fields; rst asserted mid-word -> no strobe, outputs zero.

Source files
------------

// File: rtl/ar_rxd_multi_if.sv
// ARINC-429 receiver bus bundle: line inputs, rate select, decoded word and strobes.
interface ar_rxd_multi_if;
    logic        Inp1;
    logic        Inp0;
    logic [1:0]  speed;
    logic [7:0]  sr_adr;
    logic [22:0] sr_dat;
    logic        par_ok;
    logic        ce_wr;
    logic        err_len;
    logic        err_gap;
    logic        err_code;

    modport master (
        output Inp1, Inp0, speed,
        input  sr_adr, sr_dat, par_ok, ce_wr, err_len, err_gap, err_code
    );

    modport slave (
        input  Inp1, Inp0, speed,
        output sr_adr, sr_dat, par_ok, ce_wr, err_len, err_gap, err_code
    );
endinterface

// File: rtl/ar_rxd_multi.sv
// ARINC-429 receiver: synchronizes and filters the two-wire line, frames
// 32-bit words on inter-word gaps, and reports good words and error strobes.
module ar_rxd_multi #(
    parameter int CLK_HZ = 50_000_000,
    parameter int FILT   = 4,
    parameter int TW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    ar_rxd_multi_if.slave bus
);
    // Line codes as {Inp1, Inp0}
    localparam logic [1:0] L_NULL = 2'b00;
    localparam logic [1:0] L_ZERO = 2'b01;
    localparam logic [1:0] L_ONE  = 2'b10;
    localparam logic [1:0] L_ILL  = 2'b11;

    localparam int FW = $clog2(FILT + 1);

    // Gap threshold is two bit periods at each rate
    localparam logic [TW-1:0] G_100 = TW'(2 * CLK_HZ / 100_000);
    localparam logic [TW-1:0] G_50  = TW'(2 * CLK_HZ / 50_000);
    localparam logic [TW-1:0] G_12  = TW'(2 * CLK_HZ / 12_500);
    localparam logic [TW-1:0] G_MAX = '1;

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_RX} state_t;

    state_t          r_state, w_nstate;
    logic [1:0]      r_sync1, r_sync2;
    logic [1:0]      r_cand, r_line;
    logic [FW-1:0]   r_fcnt;
    logic [TW-1:0]   r_gap, r_thr, w_thr, w_spd_thr;
    logic [30:0]     r_sh;
    logic [5:0]      r_bcnt;
    logic [7:0]      r_adr;
    logic [22:0]     r_dat, w_dat;
    logic            r_par;
    logic            r_ce, r_elen, r_egap, r_ecode;
    logic            w_acc, w_bit, w_bval, w_ill, w_null, w_gap_hit;
    logic            w_ce, w_elen, w_egap, w_ecode, w_first, w_shift;
    logic [31:0]     w_word;

    // Two-flop synchronizer on both line wires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= L_NULL;
            r_sync2 <= L_NULL;
        end else begin
            r_sync1 <= {bus.Inp1, bus.Inp0};
            r_sync2 <= r_sync1;
        end
    end

    // Level filter: a candidate must be seen FILT samples in a row to be accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand <= L_NULL;
            r_fcnt <= '0;
            r_line <= L_NULL;
        end else begin
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_fcnt <= FW'(1);
            end else if (r_fcnt != FW'(FILT)) begin
                r_fcnt <= r_fcnt + FW'(1);
            end
            if (w_acc)
                r_line <= r_cand;
        end
    end

    assign w_acc     = (r_fcnt == FW'(FILT)) && (r_cand != r_line);
    assign w_bit     = w_acc && (r_line == L_NULL) && ((r_cand == L_ONE) || (r_cand == L_ZERO));
    assign w_bval    = (r_cand == L_ONE);
    assign w_ill     = w_acc && (r_cand == L_ILL);
    assign w_null    = (r_line == L_NULL);
    assign w_gap_hit = w_null && (r_gap >= w_thr);

    // Rate decode; 11 is reserved and runs at the slow rate
    always_comb begin
        case (bus.speed)
            2'b00:   w_spd_thr = G_100;
            2'b01:   w_spd_thr = G_50;
            default: w_spd_thr = G_12;
        endcase
    end

    // The rate follows the input only while hunting for a gap; a word in flight keeps its rate
    assign w_thr = (r_state == S_SYNC) ? w_spd_thr : r_thr;

    // Latch the rate threshold while in SYNC
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_thr <= '0;
        else if (r_state == S_SYNC)
            r_thr <= w_spd_thr;
    end

    // Gap counter: consecutive accepted NULL cycles, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_gap <= '0;
        else if (w_bit || !w_null)
            r_gap <= '0;
        else if (r_gap != G_MAX)
            r_gap <= r_gap + TW'(1);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_SYNC;
        else
            r_state <= w_nstate;
    end

    // FSM next state and strobe decisions; an illegal line overrides everything
    always_comb begin
        w_nstate = r_state;
        w_ce     = 1'b0;
        w_elen   = 1'b0;
        w_egap   = 1'b0;
        w_ecode  = 1'b0;
        w_first  = 1'b0;
        w_shift  = 1'b0;
        if (w_ill) begin
            w_ecode  = 1'b1;
            w_nstate = S_SYNC;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_bit) begin
                        // A bit landing on the very cycle the gap completes starts a word
                        if (w_gap_hit) begin
                            w_nstate = S_RX;
                            w_first  = 1'b1;
                        end else begin
                            w_egap = 1'b1;
                        end
                    end else if (w_gap_hit) begin
                        w_nstate = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_bit) begin
                        w_nstate = S_RX;
                        w_first  = 1'b1;
                    end
                end
                S_RX: begin
                    if (w_bit) begin
                        if (r_bcnt == 6'd31) begin
                            w_ce     = 1'b1;
                            w_nstate = S_SYNC;
                        end else begin
                            w_shift = 1'b1;
                        end
                    end else if (w_gap_hit) begin
                        w_elen   = 1'b1;
                        w_nstate = S_IDLE;
                    end
                end
                default: w_nstate = S_SYNC;
            endcase
        end
    end

    // Bit shift register and bit counter; first bit received ends up in the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh   <= '0;
            r_bcnt <= '0;
        end else if (w_first) begin
            r_sh   <= {30'd0, w_bval};
            r_bcnt <= 6'd1;
        end else if (w_shift) begin
            r_sh   <= {r_sh[29:0], w_bval};
            r_bcnt <= r_bcnt + 6'd1;
        end
    end

    // Full word as it stands when bit 32 arrives: w_word[31] is bit 1
    assign w_word = {r_sh, w_bval};

    // Data bits 9..31 land LSB-first in sr_dat
    always_comb begin
        w_dat = '0;
        for (int i = 0; i < 23; i++)
            w_dat[i] = w_word[23-i];
    end

    // Output registers: fields change only with ce_wr; strobes last one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr   <= '0;
            r_dat   <= '0;
            r_par   <= 1'b0;
            r_ce    <= 1'b0;
            r_elen  <= 1'b0;
            r_egap  <= 1'b0;
            r_ecode <= 1'b0;
        end else begin
            r_ce    <= w_ce;
            r_elen  <= w_elen;
            r_egap  <= w_egap;
            r_ecode <= w_ecode;
            if (w_ce) begin
                r_adr <= w_word[31:24];
                r_dat <= w_dat;
                r_par <= ^w_word;
            end
        end
    end

    assign bus.sr_adr   = r_adr;
    assign bus.sr_dat   = r_dat;
    assign bus.par_ok   = r_par;
    assign bus.ce_wr    = r_ce;
    assign bus.err_len  = r_elen;
    assign bus.err_gap  = r_egap;
    assign bus.err_code = r_ecode;
endmodule

// File: tb/tb_ar_rxd_multi.sv
// Testbench for ar_rxd_multi: scripted line scenarios with random word content,
// a word-level model predicting each strobe, and a scoreboard monitor.
module tb_ar_rxd_multi;
    // Slow clock figure keeps whole words short in simulation; periods scale with it
    localparam int CLK_HZ = 5_000_000;
    localparam int K_WR = 0, K_LEN = 1, K_GAP = 2, K_CODE = 3;

    typedef struct {
        int          kind;
        logic [7:0]  adr;
        logic [22:0] dat;
        logic        par;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   p_cur;
    exp_t q[$];

    logic [7:0]  m_adr;
    logic [22:0] m_dat;
    logic        m_par;

    always #10 clk = ~clk;

    ar_rxd_multi_if bus();

    ar_rxd_multi #(.CLK_HZ(CLK_HZ), .FILT(4), .TW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int rate_p(input logic [1:0] s);
        case (s)
            2'b00:   return CLK_HZ / 100_000;
            2'b01:   return CLK_HZ / 50_000;
            default: return CLK_HZ / 12_500;
        endcase
    endfunction

    // Transmission order: label MSB first, then data LSB first, then parity bit
    function automatic logic [31:0] pack(input logic [7:0] lab, input logic [22:0] d, input logic pb);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)  s[31-i] = lab[7-i];
        for (int j = 0; j < 23; j++) s[23-j] = d[j];
        s[0] = pb;
        return s;
    endfunction

    task automatic expect_ev(input int k);
        exp_t e;
        e.kind = k; e.adr = m_adr; e.dat = m_dat; e.par = m_par;
        q.push_back(e);
    endtask

    task automatic line(input logic a1, input logic a0, input int n);
        bus.Inp1 = a1;
        bus.Inp0 = a0;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        line(b, !b, p_cur / 2);
        line(1'b0, 1'b0, p_cur - p_cur / 2);
    endtask

    // Bit with a short 11 spike in the middle of its active half
    task automatic send_bit_glitch(input logic b);
        line(b, !b, p_cur / 4);
        line(1'b1, 1'b1, 3);
        line(b, !b, p_cur / 2 - p_cur / 4 - 3);
        line(1'b0, 1'b0, p_cur - p_cur / 2);
    endtask

    task automatic send_seq(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) send_bit(s[31-i]);
    endtask

    task automatic gap();
        line(1'b0, 1'b0, 2 * p_cur + p_cur / 2);
    endtask

    task automatic good_word(input logic [7:0] lab, input logic [22:0] d, input logic pb, input bit glitch);
        logic [31:0] s;
        m_adr = lab; m_dat = d; m_par = ^{lab, d, pb};
        expect_ev(K_WR);
        s = pack(lab, d, pb);
        for (int i = 0; i < 32; i++) begin
            if (glitch && i == 6) send_bit_glitch(s[31-i]);
            else                  send_bit(s[31-i]);
        end
    endtask

    task automatic rand_word();
        good_word(8'($urandom), 23'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic drain(input string nm, input int lim);
        int c;
        c = 0;
        while (q.size() != 0 && c < lim) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected strobes never arrived, required 0 outstanding", nm, q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (bus.sr_adr !== 8'h00 || bus.sr_dat !== 23'h0 || bus.par_ok !== 1'b0 ||
            {bus.ce_wr, bus.err_len, bus.err_gap, bus.err_code} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: adr=%h dat=%h par=%b strobes=%b, required all zero", nm,
                     bus.sr_adr, bus.sr_dat, bus.par_ok,
                     {bus.ce_wr, bus.err_len, bus.err_gap, bus.err_code});
        end
    endtask

    // Scoreboard monitor: every strobe must match the next predicted event
    always @(negedge clk) begin
        int   ns;
        int   kind;
        exp_t e;
        if (!rst) begin
            ns = int'(bus.ce_wr) + int'(bus.err_len) + int'(bus.err_gap) + int'(bus.err_code);
            if (ns != 0) begin
                kind = bus.err_code ? K_CODE : bus.err_len ? K_LEN : bus.err_gap ? K_GAP : K_WR;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got kind=%0d count=%0d, required no strobe", kind, ns);
                end else begin
                    e = q.pop_front();
                    if (ns != 1 || kind != e.kind || bus.sr_adr !== e.adr ||
                        bus.sr_dat !== e.dat || bus.par_ok !== e.par) begin
                        errors++;
                        $display("FAIL strobe: got kind=%0d count=%0d adr=%h dat=%h par=%b, required kind=%0d count=1 adr=%h dat=%h par=%b",
                                 kind, ns, bus.sr_adr, bus.sr_dat, bus.par_ok, e.kind, e.adr, e.dat, e.par);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        int          n;
        bus.Inp1 = 1'b0; bus.Inp0 = 1'b0; bus.speed = 2'b01;
        m_adr = '0; m_dat = '0; m_par = 1'b0;
        p_cur = rate_p(2'b01);

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_zero("reset_state");
        @(posedge clk);
        rst = 1'b0;

        // Good word with correct odd parity, then with parity inverted
        gap();
        good_word(8'h81, 23'h2AAAAA, ~^{8'h81, 23'h2AAAAA}, 1'b0);
        drain("word_odd", 100);
        gap();
        good_word(8'h81, 23'h2AAAAA, ^{8'h81, 23'h2AAAAA}, 1'b0);
        drain("word_even", 100);

        // Random words
        for (int k = 0; k < 3; k++) begin
            gap();
            rand_word();
            drain("word_rand", 100);
        end

        // Short words: 20 bits, then a random length, then a good word from IDLE
        gap();
        expect_ev(K_LEN);
        send_seq(32'($urandom), 20);
        line(1'b0, 1'b0, 2 * p_cur + 10);
        drain("len20", 100);
        n = $urandom_range(1, 31);
        expect_ev(K_LEN);
        send_seq(32'($urandom), n);
        line(1'b0, 1'b0, 2 * p_cur + 10);
        drain("len_rand", 100);
        rand_word();
        drain("word_after_len", 100);

        // Short gap after a word: every bit is a gap error until a full gap is seen
        line(1'b0, 1'b0, p_cur);
        for (int k = 0; k < 3; k++) begin
            expect_ev(K_GAP);
            send_bit(1'($urandom));
        end
        drain("gap_short", 100);
        gap();
        rand_word();
        drain("word_after_gap", 100);

        // Illegal level during bit 5, then a word carrying a short 11 spike
        gap();
        s = 32'($urandom);
        send_seq(s, 4);
        expect_ev(K_CODE);
        line(1'b1, 1'b0, p_cur / 4);
        line(1'b1, 1'b1, 10);
        line(1'b0, 1'b0, p_cur);
        drain("code", 100);
        gap();
        good_word(8'($urandom), 23'($urandom), 1'($urandom), 1'b1);
        drain("word_glitch", 100);

        // Fast rate selected while in SYNC
        bus.speed = 2'b00;
        p_cur = rate_p(2'b00);
        gap();
        rand_word();
        drain("word_fast", 100);

        // Rate change mid-word must not alter the word's gap threshold
        gap();
        s = 32'($urandom);
        send_seq(s, 5);
        bus.speed = 2'b10;
        for (int i = 5; i < 10; i++) send_bit(s[31-i]);
        expect_ev(K_LEN);
        line(1'b0, 1'b0, 2 * p_cur + 30);
        drain("len_latched_rate", 100);
        bus.speed = 2'b00;

        // Reset mid-word: no strobe, fields cleared, full gap needed afterwards
        send_seq(32'($urandom), 10);
        rst = 1'b1;
        m_adr = '0; m_dat = '0; m_par = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_zero("reset_mid_word");
        @(posedge clk);
        rst = 1'b0;
        line(1'b0, 1'b0, 30);
        expect_ev(K_GAP);
        send_bit(1'($urandom));
        drain("gap_after_reset", 100);
        gap();
        rand_word();
        drain("word_after_reset", 100);

        repeat (20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
